// File: rtl/sfx_scheduler.sv
// rtl/sfx_scheduler.sv - one-shot sound effect sequencer for music voice 1
//
// Arbitrates full-row, level-up and game-over requests (OVER > LVL > ROW),
// plays the selected effect as a stepped note sequence and drives the
// voice-1 override into freq_gen. After the game-over jingle the music clock
// is paused until restart.
//
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   full_row           row-clear request, rising-edge detected
//   level_up           level-up request, rising-edge detected
//   game_over          game-over request, rising-edge detected
//   restart            leaves HALT (ignored elsewhere)
//   inlevel[3:0]       current level, latched when a level-up effect starts
//   sfx_active         1 = voice 1 plays sfx_freq instead of the song note
//   sfx_freq[6:0]      note index for freq_gen
//   music_pause        freezes the music clock while halted
//   sfx_kind[1:0]      0 none, 1 row, 2 level, 3 game over
module sfx_scheduler #(
  parameter int unsigned TICK_BITS = 18,
  parameter logic [6:0]  ROW_BASE  = 7'd20,
  parameter logic [6:0]  LVL_BASE  = 7'd40,
  parameter logic [6:0]  OVER_BASE = 7'd60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       full_row,
  input  logic       level_up,
  input  logic       game_over,
  input  logic       restart,
  input  logic [3:0] inlevel,
  output logic       sfx_active,
  output logic [6:0] sfx_freq,
  output logic       music_pause,
  output logic [1:0] sfx_kind
);

  typedef enum logic [2:0] {S_IDLE, S_ROW, S_LVL, S_OVER, S_HALT} state_t;

  localparam logic [TICK_BITS-1:0] TICK_ONE = TICK_BITS'(1);
  localparam logic [TICK_BITS-1:0] TICK_MAX = {TICK_BITS{1'b1}};

  state_t               state_q, state_d;
  logic [4:0]           step_q, step_d;
  logic [TICK_BITS-1:0] tick_q, tick_d;
  logic [3:0]           lvl_cap_q, lvl_cap_d;
  logic                 pend_row_q, pend_row_d;
  logic                 pend_lvl_q, pend_lvl_d;
  logic                 row_in_q, lvl_in_q, over_in_q;

  logic       row_e, lvl_e, over_e;
  logic [1:0] cur_prio, edge_prio;
  logic [4:0] last_step;
  logic       start_en;
  state_t     start_st;
  logic [6:0] freq_d;
  logic [7:0] row_sum, lvl_sum, lvl_off;

  assign row_e  = full_row  & ~row_in_q;
  assign lvl_e  = level_up  & ~lvl_in_q;
  assign over_e = game_over & ~over_in_q;

  function automatic state_t prio_to_state(input logic [1:0] p);
    case (p)
      2'd1:    return S_ROW;
      2'd2:    return S_LVL;
      2'd3:    return S_OVER;
      default: return S_IDLE;
    endcase
  endfunction

  function automatic logic [6:0] sat_hi(input logic [7:0] v);
    return v[7] ? 7'd127 : v[6:0];
  endfunction

  always_comb begin
    case (state_q)
      S_ROW:   begin cur_prio = 2'd1; last_step = 5'd15; end
      S_LVL:   begin cur_prio = 2'd2; last_step = 5'd15; end
      S_OVER:  begin cur_prio = 2'd3; last_step = 5'd23; end
      default: begin cur_prio = 2'd0; last_step = 5'd0;  end
    endcase
    edge_prio = over_e ? 2'd3 : lvl_e ? 2'd2 : row_e ? 2'd1 : 2'd0;
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    tick_d     = tick_q;
    lvl_cap_d  = lvl_cap_q;
    pend_row_d = pend_row_q;
    pend_lvl_d = pend_lvl_q;
    start_en   = 1'b0;
    start_st   = S_IDLE;

    if (state_q == S_HALT) begin
      if (restart) state_d = S_IDLE;
    end else begin
      // Every edge is recorded as pending; the one that actually starts is
      // cleared again below, so non-winning simultaneous edges stay queued.
      pend_row_d = pend_row_q | row_e;
      pend_lvl_d = pend_lvl_q | lvl_e;
      if (edge_prio > cur_prio) begin
        start_en = 1'b1;
        start_st = prio_to_state(edge_prio);
      end else if (state_q != S_IDLE) begin
        tick_d = tick_q + TICK_ONE;
        if (tick_q == TICK_MAX) begin
          if (step_q == last_step) begin
            if (state_q == S_OVER) begin
              state_d    = S_HALT;
              pend_row_d = 1'b0;
              pend_lvl_d = 1'b0;
            end else if (pend_lvl_d) begin
              start_en = 1'b1;
              start_st = S_LVL;
            end else if (pend_row_d) begin
              start_en = 1'b1;
              start_st = S_ROW;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            step_d = step_q + 5'd1;
          end
        end
      end
    end

    if (start_en) begin
      state_d = start_st;
      step_d  = 5'd0;
      tick_d  = '0;
      if (start_st == S_LVL) begin
        lvl_cap_d  = inlevel;
        pend_lvl_d = 1'b0;
      end
      if (start_st == S_ROW) pend_row_d = 1'b0;
    end
  end

  // Outputs are computed from the next state so they register together with it.
  always_comb begin
    case (step_d[3:2])
      2'd0:    lvl_off = 8'd0;
      2'd1:    lvl_off = 8'd4;
      2'd2:    lvl_off = 8'd7;
      default: lvl_off = 8'd12;
    endcase
    row_sum = {1'b0, ROW_BASE} + {2'b00, step_d, 1'b0};
    lvl_sum = {1'b0, LVL_BASE} + {4'b0000, lvl_cap_d} + lvl_off;
    case (state_d)
      S_ROW:   freq_d = sat_hi(row_sum);
      S_LVL:   freq_d = sat_hi(lvl_sum);
      S_OVER:  freq_d = ({3'b000, step_d} > {1'b0, OVER_BASE}) ? 7'd0
                        : 7'(({1'b0, OVER_BASE} - {3'b000, step_d}));
      default: freq_d = 7'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      step_q      <= 5'd0;
      tick_q      <= '0;
      lvl_cap_q   <= 4'd0;
      pend_row_q  <= 1'b0;
      pend_lvl_q  <= 1'b0;
      row_in_q    <= 1'b0;
      lvl_in_q    <= 1'b0;
      over_in_q   <= 1'b0;
      sfx_active  <= 1'b0;
      sfx_freq    <= 7'd0;
      music_pause <= 1'b0;
      sfx_kind    <= 2'd0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      tick_q      <= tick_d;
      lvl_cap_q   <= lvl_cap_d;
      pend_row_q  <= pend_row_d;
      pend_lvl_q  <= pend_lvl_d;
      row_in_q    <= full_row;
      lvl_in_q    <= level_up;
      over_in_q   <= game_over;
      sfx_active  <= (state_d == S_ROW) || (state_d == S_LVL) || (state_d == S_OVER);
      sfx_freq    <= freq_d;
      music_pause <= (state_d == S_HALT);
      case (state_d)
        S_ROW:   sfx_kind <= 2'd1;
        S_LVL:   sfx_kind <= 2'd2;
        S_OVER:  sfx_kind <= 2'd3;
        default: sfx_kind <= 2'd0;
      endcase
    end
  end

endmodule
